aes_dec_addkey_imc: RTL and testbench
=====================================

AES_DEC_ADDKEY_IMC -- requirements
Module: aes_dec_addkey_imc

Interface
REQ-001 SHALL have no parameters; all widths fixed (128-bit state, 32-bit column, 8-bit byte).
REQ-002 SHALL have ports: clk  in  1  single clock, all state updated on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  upstream presents state_in/rkey_in/bypass_imc.
REQ-005 SHALL have ports: in_ready  out  1  block can accept; transfer on in_valid & in_ready at a clock edge.
REQ-006 SHALL have ports: state_in  in  128  decryption state after InvShiftRows/InvSubBytes.
REQ-007 SHALL have ports: rkey_in  in  128  round key for this round.
REQ-008 SHALL have ports: bypass_imc  in  1  final round; skip InvMixColumns.
REQ-009 SHALL have ports: flush  in  1  synchronous abort.
REQ-010 SHALL have ports: out_valid  out  1  state_out holds a result.
REQ-011 SHALL have ports: out_ready  in  1  downstream accepts; transfer on out_valid & out_ready.
REQ-012 SHALL have ports: state_out  out  128  round result.
REQ-013 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL lay out the state column-major: column c = bits [127-32c : 96-32c], c=0..3; within a column, byte [31:24] is row 0, [7:0] is row 3.
REQ-015 SHALL compute per column, over GF(2^8) mod x^8+x^4+x^3+x+1: r0=0e*a0^0b*a1^0d*a2^09*a3; r1=09*a0^0e*a1^0b*a2^0d*a3; r2=0d*a0^09*a1^0e*a2^0b*a3; r3=0b*a0^0d*a1^09*a2^0e*a3.
REQ-016 SHALL implement a three-state FSM: IDLE, MIX, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 SHALL, on an accept edge, load the work register with state_in XOR rkey_in, clear the 2-bit column counter to 0, and enter DONE if bypass_imc=1, else MIX.
REQ-018 SHALL, in MIX, on each edge replace column[col_cnt] of the work register with its InvMixColumns result and increment col_cnt; the edge with col_cnt==3 enters DONE and wraps col_cnt to 0.
REQ-019 SHALL use one column datapath only; other columns stay unchanged in that cycle.
REQ-020 SHALL give latency from the accept edge to out_valid high of 1 edge (bypass) or 5 edges (mix); no pipelined overlap; in_ready stays low until return to IDLE.
REQ-021 SHALL, in DONE, hold state_out and out_valid stable while out_ready=0; on out_valid & out_ready, return to IDLE at that edge.
REQ-022 SHALL drive state_out from the work register at all times; it may show partial results while in MIX.
REQ-023 SHALL give flush priority over every other event: on any edge with flush=1, go to IDLE and set col_cnt=0; the work register is unchanged; an in_valid or out_ready in the same cycle is ignored and no transfer occurs.
REQ-024 SHALL ignore the input bus contents when no accept happens; bypass_imc is sampled only on the accept edge.

Reset
REQ-025 SHALL, while reset_n=0 and independent of clk: state=IDLE, col_cnt=0, work register=0, so state_out=0, out_valid=0, in_ready=1, busy=0.
REQ-026 SHALL abandon any in-progress operation on reset assertion mid-MIX or mid-DONE; the first accept after release behaves per REQ-017.

Verification
REQ-027 SHALL check mix: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6, rkey_in=0, bypass=0 -> out_valid 5 edges after accept, state_out=db135345_f20a225c_01010101_c6c6c6c6.
REQ-028 SHALL check key XOR: state_in=0, rkey_in=4d7ebdf8_d5d5d7d6_8e4da1bc_00000000, bypass=0 -> state_out=2d26314c_d4d4d4d5_db135345_00000000.
REQ-029 SHALL check bypass: state_in=00112233_44556677_8899aabb_ccddeeff, rkey_in=ffffffff_ffffffff_ffffffff_ffffffff, bypass=1 -> out_valid 1 edge after accept, state_out=ffeeddcc_bbaa9988_77665544_33221100.
REQ-030 SHALL check backpressure: out_ready=0 for 3 cycles after out_valid -> out_valid and state_out stable; in_valid=1 meanwhile is not accepted; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 SHALL check flush: flush=1 on the second MIX edge -> IDLE next edge, out_valid never asserted; a new transaction then completes correctly per REQ-027.
REQ-032 SHALL check reset mid-MIX: reset_n=0 asynchronously -> in_ready=1, out_valid=0, state_out=0 immediately; after release, back-to-back transactions complete with correct results.

Source files
------------

// File: rtl/aes_dec_addkey_imc_if.sv
// rtl/aes_dec_addkey_imc_if.sv - handshake and data bus for the AddRoundKey/InvMixColumns round stage
interface aes_dec_addkey_imc_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] rkey_in;
    logic         bypass_imc;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, rkey_in, bypass_imc, flush, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, rkey_in, bypass_imc, flush, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/aes_dec_addkey_imc.sv
// rtl/aes_dec_addkey_imc.sv - AES decryption round tail: AddRoundKey then column-serial InvMixColumns
module aes_dec_addkey_imc (
    input  logic                    clk,
    input  logic                    reset_n,
    aes_dec_addkey_imc_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [1:0]   r_col_cnt;
    logic [127:0] r_work;

    logic [31:0]  w_col_in;
    logic [31:0]  w_col_mix;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Row 0 lives in the top byte of each column.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
    endfunction

    always_comb begin
        w_col_in = '0;
        case (r_col_cnt)
            2'd0: w_col_in = r_work[127:96];
            2'd1: w_col_in = r_work[95:64];
            2'd2: w_col_in = r_work[63:32];
            2'd3: w_col_in = r_work[31:0];
            default: w_col_in = '0;
        endcase
    end

    assign w_col_mix = inv_mix_col(w_col_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_col_cnt <= 2'd0;
            r_work    <= '0;
        end else if (bus.flush) begin
            // Abort leaves the work register as-is; only control state is cleared.
            r_state   <= IDLE;
            r_col_cnt <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_work    <= bus.state_in ^ bus.rkey_in;
                        r_col_cnt <= 2'd0;
                        r_state   <= bus.bypass_imc ? DONE : MIX;
                    end
                end
                MIX: begin
                    case (r_col_cnt)
                        2'd0: r_work[127:96] <= w_col_mix;
                        2'd1: r_work[95:64]  <= w_col_mix;
                        2'd2: r_work[63:32]  <= w_col_mix;
                        2'd3: r_work[31:0]   <= w_col_mix;
                        default: ;
                    endcase
                    r_col_cnt <= r_col_cnt + 2'd1;
                    if (r_col_cnt == 2'd3) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.state_out = r_work;

endmodule

// File: tb/tb_aes_dec_addkey_imc.sv
// tb/tb_aes_dec_addkey_imc.sv - directed vector bench for aes_dec_addkey_imc
module tb_aes_dec_addkey_imc;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    aes_dec_addkey_imc_if bus ();

    aes_dec_addkey_imc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] state_in;
        logic [127:0] rkey_in;
        logic         bypass;
        logic [127:0] expect_out;
        int           latency;
    } vec_t;

    vec_t vecs[5];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
    task automatic run_txn(input string name, input vec_t v);
        int  n;
        logic got;
        bus.state_in   = v.state_in;
        bus.rkey_in    = v.rkey_in;
        bus.bypass_imc = v.bypass;
        bus.in_valid   = 1'b1;
        chk({name, "_in_ready_before"}, {127'd0, bus.in_ready}, 128'd1);
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (k == 0) begin
                bus.in_valid   = 1'b0;
                bus.bypass_imc = ~v.bypass;
                bus.state_in   = '1;
                chk({name, "_in_ready_after_accept"}, {127'd0, bus.in_ready}, 128'd0);
            end
            if (bus.out_valid) got = 1'b1;
        end
        chk({name, "_latency"}, 128'(n), 128'(v.latency));
        chk({name, "_state_out"}, bus.state_out, v.expect_out);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_idle_after_drain"}, {126'd0, bus.in_ready, bus.out_valid}, 128'd2);
    endtask

    logic [127:0] held;
    logic         saw_valid;

    initial begin
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6, 5};
        vecs[1] = '{128'h0, 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_00000000, 1'b0,
                    128'h2d26314c_d4d4d4d5_db135345_00000000, 5};
        vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}}, 1'b1,
                    128'hffeeddcc_bbaa9988_77665544_33221100, 1};
        vecs[3] = '{128'h01234567_89abcdef_fedcba98_76543210,
                    128'h01234567_89abcdef_fedcba98_76543210, 1'b0, 128'h0, 5};
        vecs[4] = '{128'h01010101_01010101_01010101_01010101, 128'h0, 1'b0,
                    128'h01010101_01010101_01010101_01010101, 5};

        bus.in_valid   = 1'b0;
        bus.state_in   = '0;
        bus.rkey_in    = '0;
        bus.bypass_imc = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;

        #12;
        chk("reset_in_ready",  {127'd0, bus.in_ready},  128'd1);
        chk("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("reset_busy",      {127'd0, bus.busy},      128'd0);
        chk("reset_state_out", bus.state_out,           128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold out_ready low with a competing in_valid.
        bus.state_in   = vecs[2].state_in;
        bus.rkey_in    = vecs[2].rkey_in;
        bus.bypass_imc = 1'b1;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.state_in   = 128'h0;
        bus.rkey_in    = 128'h1234;
        held = bus.state_out;
        chk("bp_first_out", held, vecs[2].expect_out);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k),
                {bus.state_out, bus.out_valid, bus.in_ready} ,
                {held, 1'b1, 1'b0} );
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_idle", {126'd0, bus.in_ready, bus.out_valid}, 128'd2);

        // Flush on the second MIX edge: only column 0 has been mixed.
        bus.state_in   = vecs[0].state_in;
        bus.rkey_in    = vecs[0].rkey_in;
        bus.bypass_imc = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_idle", {126'd0, bus.in_ready, bus.busy}, 128'd2);
        chk("flush_work_kept", bus.state_out, 128'hdb135345_9fdc589d_01010101_c6c6c6c6);
        saw_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("flush_no_out_valid", {127'd0, saw_valid}, 128'd0);
        run_txn("after_flush", vecs[0]);

        // Asynchronous reset in the middle of MIX.
        bus.state_in   = vecs[1].state_in;
        bus.rkey_in    = vecs[1].rkey_in;
        bus.bypass_imc = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_in_ready",  {127'd0, bus.in_ready},  128'd1);
        chk("rst_mid_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_mid_state_out", bus.state_out,           128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_txn("b2b_a", vecs[0]);
        run_txn("b2b_b", vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
